set_job_sched: RTL and testbench
================================

SET_JOB_SCHED -- requirements
Module: set_job_sched

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, job queue entries (power of two, 2..16).
REQ-002 SHALL provide parameter TIMEOUT, default 1024, maximum cycles to wait for engine valid.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide req_valid in 1, req_ready out 1, req_central in 24, req_radius in 12, req_mode in 2, req_tag in 4: host job push, valid/ready handshake.
REQ-006 SHALL provide eng_en out 1, eng_central out 24, eng_radius out 12, eng_mode out 2: job issue to the SET engine.
REQ-007 SHALL provide eng_busy in 1, eng_valid in 1, eng_candidate in 8: engine status and result.
REQ-008 SHALL provide rsp_valid out 1, rsp_ready in 1, rsp_candidate out 8, rsp_tag out 4, rsp_mode out 2: result return, valid/ready handshake.
REQ-009 SHALL provide pending out 5 (queued job count) and timeout_err out 1 (sticky).

Function
REQ-010 Queue SHALL be a DEPTH-entry FIFO of {central, radius, mode, tag}; push occurs when req_valid && req_ready.
REQ-011 req_ready SHALL equal !full, combinational from the count; a push is never accepted when full.
REQ-012 A simultaneous push and pop SHALL leave pending unchanged; pointers wrap modulo DEPTH.
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE->ISSUE SHALL occur when the queue is non-empty, eng_busy==0, and (!rsp_valid || rsp_ready); on this transition the head pops into the issue registers.
REQ-015 In ISSUE, eng_en SHALL be high for exactly one cycle, with eng_central/radius/mode driven from the issue registers; next state is WAIT.
REQ-016 eng_central, eng_radius and eng_mode SHALL remain stable from ISSUE until the result is captured.
REQ-017 In WAIT, eng_valid==1 SHALL capture eng_candidate, the issue tag and the issue mode into the response registers, set rsp_valid the next cycle, and enter RESP.
REQ-018 In RESP, rsp_valid SHALL hold its data stable until rsp_ready; on the handshake it goes to IDLE, or may enter ISSUE directly if REQ-014 conditions hold.
REQ-019 eng_valid outside WAIT SHALL be ignored.
REQ-020 Minimum latency SHALL be: push at cycle N into an empty queue in IDLE -> eng_en at N+2; eng_valid at M -> rsp_valid at M+1.
REQ-021 Jobs SHALL complete in push order; exactly one job is in flight at a time.

Reset
REQ-022 rst low SHALL asynchronously clear the queue (pending=0), return the FSM to IDLE, and drive eng_en=0, rsp_valid=0, rsp_candidate=0, rsp_tag=0, rsp_mode=0, eng_central=0, eng_radius=0, eng_mode=0, timeout_err=0, req_ready=1 after release.
REQ-023 A reset mid-job SHALL drop the in-flight job and all queued jobs without producing a response.

Configuration
REQ-024 Macro SET_SCHED_TIMEOUT_EN defined: a WAIT-cycle counter SHALL run; when it reaches TIMEOUT without eng_valid, the block SHALL return rsp_candidate=8'hFF with the job's tag and set timeout_err.
REQ-025 Macro SET_SCHED_TIMEOUT_EN undefined: no counter SHALL exist, WAIT is left only on eng_valid, and timeout_err is tied to 0.

Verification
REQ-026 Single job: push central=24'h344552, radius=12'h333, mode=2, tag=5 to an idle block with engine latency 20 -> one eng_en pulse, rsp_valid with tag=5, mode=2 and the engine candidate.
REQ-027 Fill: push 5 jobs with the engine held busy -> req_ready=0 after 4, pending=4; release busy -> all 5 responses in tag order 0..4.
REQ-028 Backpressure: rsp_ready=0 for 30 cycles with 2 jobs queued -> no second eng_en until the first response is accepted; rsp data stable throughout.
REQ-029 Spurious eng_valid in IDLE with candidate 8'h22 -> no rsp_valid, no state change.
REQ-030 Reset asserted during WAIT -> eng_en and rsp_valid are 0 immediately, pending=0, and no response appears after release.
REQ-031 With SET_SCHED_TIMEOUT_EN and TIMEOUT=16, engine never responds -> rsp_candidate=8'hFF at WAIT cycle 16, timeout_err=1, and the next job issues normally.

Source files
------------

// File: rtl/set_job_sched.sv
// set_job_sched: FIFO-fed scheduler that issues one SET job at a time and returns tagged results.
// Define SET_SCHED_TIMEOUT_EN to add a WAIT watchdog that answers 8'hFF and sets timeout_err.
module set_job_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_central,
    input  logic [11:0] req_radius,
    input  logic [1:0]  req_mode,
    input  logic [3:0]  req_tag,
    output logic        eng_en,
    output logic [23:0] eng_central,
    output logic [11:0] eng_radius,
    output logic [1:0]  eng_mode,
    input  logic        eng_busy,
    input  logic        eng_valid,
    input  logic [7:0]  eng_candidate,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_candidate,
    output logic [3:0]  rsp_tag,
    output logic [1:0]  rsp_mode,
    output logic [4:0]  pending,
    output logic        timeout_err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t        state_q;
    logic [41:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [4:0]    cnt_q, cnt_d;
    logic          push, pop;
    logic          eng_en_q, rsp_valid_q;
    logic [23:0]   central_q;
    logic [11:0]   radius_q;
    logic [1:0]    mode_q, rmode_q;
    logic [3:0]    tag_q, rtag_q;
    logic [7:0]    cand_q;
`ifdef SET_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif
    assign req_ready     = cnt_q != 5'(DEPTH);
    assign push          = req_valid && req_ready;
    // Pop straight into the issue registers, either from IDLE or on the RESP handshake.
    assign pop           = cnt_q != 5'd0 && !eng_busy &&
                           ((state_q == IDLE && (!rsp_valid_q || rsp_ready)) || (state_q == RESP && rsp_ready));
    assign cnt_d         = cnt_q + 5'(push) - 5'(pop);
    assign pending       = cnt_q;
    assign eng_en        = eng_en_q;
    assign eng_central   = central_q;
    assign eng_radius    = radius_q;
    assign eng_mode      = mode_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_candidate = cand_q;
    assign rsp_tag       = rtag_q;
    assign rsp_mode      = rmode_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {req_central, req_radius, req_mode, req_tag};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= push ? wr_q + AW'(1) : wr_q;
            rd_q  <= pop ? rd_q + AW'(1) : rd_q;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            eng_en_q    <= 1'b0;
            central_q   <= '0;
            radius_q    <= '0;
            mode_q      <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            cand_q      <= '0;
            rtag_q      <= '0;
            rmode_q     <= '0;
`ifdef SET_SCHED_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ISSUE: begin
                    eng_en_q <= 1'b0;
                    state_q  <= WAIT;
`ifdef SET_SCHED_TIMEOUT_EN
                    tmo_q    <= '0;
`endif
                end
                WAIT: begin
                    if (eng_valid) begin
                        cand_q      <= eng_candidate;
                        rtag_q      <= tag_q;
                        rmode_q     <= mode_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
`ifdef SET_SCHED_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        cand_q      <= 8'hFF;
                        rtag_q      <= tag_q;
                        rmode_q     <= mode_q;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: ;
            endcase
            if (pop) begin
                state_q  <= ISSUE;
                eng_en_q <= 1'b1;
                {central_q, radius_q, mode_q, tag_q} <= mem_q[rd_q];
            end
        end
    end
endmodule

// File: tb/tb_set_job_sched.sv
// tb_set_job_sched: randomized scoreboard bench with a behavioural engine and job-order model.
module tb_set_job_sched;
    localparam int TMO = 16;
    typedef struct {logic [23:0] c; logic [11:0] r; logic [1:0] m; logic [3:0] t;} job_t;
    typedef struct {logic [7:0] cand; logic [3:0] t; logic [1:0] m; int vcyc;} rsp_t;

    logic clk = 1'b0, rst = 1'b0;
    logic req_valid = 1'b0, req_ready;
    logic [23:0] req_central = '0;
    logic [11:0] req_radius = '0;
    logic [1:0]  req_mode = '0;
    logic [3:0]  req_tag = '0;
    logic eng_en;
    logic [23:0] eng_central;
    logic [11:0] eng_radius;
    logic [1:0]  eng_mode;
    logic eng_busy = 1'b0, eng_valid = 1'b0;
    logic [7:0] eng_candidate = '0;
    logic rsp_valid, rsp_ready = 1'b1;
    logic [7:0] rsp_candidate;
    logic [3:0] rsp_tag;
    logic [1:0] rsp_mode;
    logic [4:0] pending;
    logic timeout_err;

    int total = 0, bad = 0, cyc = 0;
    int lat_min = 1, lat_max = 1, rdy_mode = 0, busy_mode = 0;
    int n_en = 0, eng_cnt = -1, spur_req = 0;
    bit never = 1'b0;
    job_t iss_q[$];
    rsp_t exp_q[$];
    logic [3:0] tag_log[$];
    job_t cur;

    set_job_sched #(.DEPTH(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_central(req_central),
        .req_radius(req_radius), .req_mode(req_mode), .req_tag(req_tag),
        .eng_en(eng_en), .eng_central(eng_central), .eng_radius(eng_radius), .eng_mode(eng_mode),
        .eng_busy(eng_busy), .eng_valid(eng_valid), .eng_candidate(eng_candidate),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_candidate(rsp_candidate),
        .rsp_tag(rsp_tag), .rsp_mode(rsp_mode), .pending(pending), .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Host-side random backpressure and engine busy, applied just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        rsp_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'($urandom);
        eng_busy  = busy_mode == 0 ? 1'b0 : busy_mode == 1 ? 1'b1 : ($urandom % 4 == 0);
    end

    // Behavioural SET engine: accepts eng_en, answers after a random latency.
    initial begin
        bit drove = 1'b0, prev_en = 1'b0;
        int spur_done = 0;
        forever begin
            @(negedge clk);
            if (drove) begin
                eng_valid = 1'b0;
                drove = 1'b0;
            end
            if (spur_req != spur_done) begin
                eng_valid = 1'b1;
                eng_candidate = 8'h22;
                drove = 1'b1;
                spur_done = spur_req;
            end
            if (!rst) begin
                eng_cnt = -1;
                prev_en = 1'b0;
            end else begin
                if (eng_en) begin
                    chk("eng_en_one_cycle", 32'(prev_en), 0);
                    n_en++;
                    if (iss_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL eng_issue: eng_en with no queued job (cycle %0d)", cyc);
                    end else begin
                        cur = iss_q.pop_front();
                        chk("eng_central", eng_central, cur.c);
                        chk("eng_radius", eng_radius, cur.r);
                        chk("eng_mode", eng_mode, cur.m);
                    end
                    eng_cnt = never ? -1 : int'($urandom_range(lat_max, lat_min));
`ifdef SET_SCHED_TIMEOUT_EN
                    if (never) exp_q.push_back('{8'hFF, cur.t, cur.m, cyc + TMO + 1});
`endif
                end else if (eng_cnt > 0) begin
                    eng_cnt--;
                end
                if (eng_cnt == 0) begin
                    chk("eng_central_stable", eng_central, cur.c);
                    chk("eng_radius_stable", eng_radius, cur.r);
                    eng_candidate = 8'($urandom);
                    eng_valid = 1'b1;
                    drove = 1'b1;
                    exp_q.push_back('{eng_candidate, cur.t, cur.m, cyc + 1});
                    eng_cnt = -1;
                end
                prev_en = eng_en;
            end
        end
    end

    // Response monitor: every valid cycle must match the scoreboard head.
    initial begin
        rsp_t e;
        bit prev_v = 1'b0, prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: tag %0h cand %0h with nothing expected", rsp_tag, rsp_candidate);
                end else begin
                    e = exp_q[0];
                    chk("rsp_candidate", rsp_candidate, e.cand);
                    chk("rsp_tag", rsp_tag, e.t);
                    chk("rsp_mode", rsp_mode, e.m);
                    if (!prev_v || prev_hs) chk("rsp_latency", cyc, e.vcyc);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        tag_log.push_back(rsp_tag);
                    end
                end
            end
            prev_v = rst && rsp_valid;
            prev_hs = rsp_ready;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m, input logic [3:0] t);
        int n = 0;
        bit ok = 1'b0;
        req_central = c;
        req_radius = r;
        req_mode = m;
        req_tag = t;
        req_valid = 1'b1;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            else n++;
        end
        if (ok) iss_q.push_back('{c, r, m, t});
        else chk("push_accept", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((iss_q.size() != 0 || exp_q.size() != 0 || eng_cnt >= 0 || pending != 0 || rsp_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(n < 3000), 1);
        step(1);
    endtask

    initial begin
        int n0, n1, w;
        step(3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_pending", pending, 0);
        chk("rst_eng_en", eng_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_candidate", rsp_candidate, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_mode", rsp_mode, 0);
        chk("rst_eng_central", eng_central, 0);
        chk("rst_eng_radius", eng_radius, 0);
        chk("rst_eng_mode", eng_mode, 0);
        chk("rst_timeout_err", timeout_err, 0);
        step(1);

        // Single job with engine latency 20 and the minimum-latency issue check.
        lat_min = 20;
        lat_max = 20;
        n0 = n_en;
        push(24'h344552, 12'h333, 2'd2, 4'd5);
        @(negedge clk);
        chk("issue_lat_n1", eng_en, 0);
        @(negedge clk);
        chk("issue_lat_n2", eng_en, 1);
        drain();
        chk("single_en_count", n_en - n0, 1);
        chk("single_tag", tag_log[tag_log.size() - 1], 5);

        // Fill with the engine busy, then release.
        lat_min = 1;
        lat_max = 3;
        busy_mode = 1;
        step(2);
        tag_log.delete();
        for (int i = 0; i < 4; i++) push(24'($urandom), 12'($urandom), 2'($urandom), 4'(i));
        @(negedge clk);
        chk("fill_req_ready", req_ready, 0);
        chk("fill_pending", pending, 4);
        req_tag = 4'd4;
        req_valid = 1'b1;
        step(3);
        @(negedge clk);
        chk("full_no_accept", pending, 4);
        busy_mode = 0;
        push(24'($urandom), 12'($urandom), 2'($urandom), 4'd4);
        drain();
        chk("fill_count", tag_log.size(), 5);
        for (int i = 0; i < 5; i++) if (tag_log.size() > i) chk("fill_order", tag_log[i], i);

        // Response backpressure with two jobs queued.
        lat_min = 3;
        lat_max = 3;
        rdy_mode = 1;
        step(2);
        n0 = n_en;
        push(24'($urandom), 12'($urandom), 2'($urandom), 4'd9);
        push(24'($urandom), 12'($urandom), 2'($urandom), 4'd10);
        step(30);
        @(negedge clk);
        chk("bp_single_issue", n_en - n0, 1);
        chk("bp_pending", pending, 1);
        chk("bp_rsp_valid", rsp_valid, 1);
        rdy_mode = 0;
        drain();
        chk("bp_second_issue", n_en - n0, 2);

        // Spurious eng_valid while idle.
        n0 = n_en;
        spur_req++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("spur_rsp_valid", rsp_valid, 0);
            chk("spur_pending", pending, 0);
        end
        step(1);
        chk("spur_no_issue", n_en - n0, 0);
        lat_min = 2;
        lat_max = 2;
        push(24'h00ABCD, 12'h0F0, 2'd1, 4'd3);
        drain();

        // Reset while a job is in WAIT with another queued.
        never = 1'b1;
        n0 = n_en;
        push(24'($urandom), 12'($urandom), 2'($urandom), 4'd7);
        push(24'($urandom), 12'($urandom), 2'($urandom), 4'd8);
        w = 0;
        while (n_en == n0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("rst_job_issued", n_en - n0, 1);
        step(3);
        rst = 1'b0;
        #1;
        chk("midrst_eng_en", eng_en, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_pending", pending, 0);
        iss_q.delete();
        exp_q.delete();
        step(2);
        rst = 1'b1;
        never = 1'b0;
        n1 = n_en;
        step(40);
        chk("midrst_no_issue", n_en - n1, 0);
        chk("midrst_req_ready", req_ready, 1);

`ifdef SET_SCHED_TIMEOUT_EN
        never = 1'b1;
        push(24'h123456, 12'h111, 2'd3, 4'd12);
        drain();
        chk("tmo_err", timeout_err, 1);
        never = 1'b0;
        push(24'h654321, 12'h222, 2'd0, 4'd13);
        drain();
`endif

        // Randomized traffic with random busy and backpressure.
        lat_min = 1;
        lat_max = 8;
        busy_mode = 2;
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            push(24'($urandom), 12'($urandom), 2'($urandom), 4'($urandom));
            step($urandom_range(2, 0));
        end
        busy_mode = 0;
        rdy_mode = 0;
        drain();
        chk("end_iss_empty", iss_q.size(), 0);
        chk("end_exp_empty", exp_q.size(), 0);
`ifndef SET_SCHED_TIMEOUT_EN
        chk("end_timeout_err", timeout_err, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
